// File: rtl/btn_conditioner_if.sv
// btn_conditioner_if: bundles the raw button pad levels and the conditioned
// outputs shared between the pad ring and the pong game wrapper.
interface btn_conditioner_if #(
  parameter int N_BTN = 6
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_n;
  logic [N_BTN-1:0] press_pulse;
  logic [N_BTN-1:0] release_pulse;

  // Pad side: drives raw levels, consumes the clean outputs.
  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_n,
    input  press_pulse,
    input  release_pulse
  );

  // Conditioner side.
  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_n,
    output press_pulse,
    output release_pulse
  );
endinterface

// File: rtl/btn_conditioner.sv
// btn_conditioner: per-button synchroniser, debounce counter, clean level,
// active-low copy and one-cycle press/release strobes. Channels are fully
// independent. Defining BTN_AUTOREPEAT_EN adds an auto-repeat generator that
// re-fires press_pulse while a REPEAT_MASK channel is held.
module btn_conditioner #(
  parameter int               N_BTN           = 6,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 250000,
  parameter int               CNT_W           = 18,
  parameter int               REPEAT_DELAY    = 6250000,
  parameter int               REPEAT_PERIOD   = 2500000,
  parameter logic [N_BTN-1:0] REPEAT_MASK     = 6'b001111
) (
  input logic              clock,
  input logic              reset_n,
  btn_conditioner_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][N_BTN-1:0] sync_r;
  logic [N_BTN-1:0][CNT_W-1:0]       cnt_r;
  logic [N_BTN-1:0][CNT_W-1:0]       cnt_nxt_s;
  logic [N_BTN-1:0]                  sync_s;
  logic [N_BTN-1:0]                  level_r;
  logic [N_BTN-1:0]                  btn_n_r;
  logic [N_BTN-1:0]                  press_r;
  logic [N_BTN-1:0]                  release_r;
  logic [N_BTN-1:0]                  toggle_s;
  logic [N_BTN-1:0]                  level_nxt_s;
  logic [N_BTN-1:0]                  rise_s;
  logic [N_BTN-1:0]                  fall_s;
  logic [N_BTN-1:0]                  rpt_fire_s;

  assign sync_s      = sync_r[SYNC_STAGES-1];
  assign level_nxt_s = level_r ^ toggle_s;
  assign rise_s      = toggle_s & ~level_r;
  assign fall_s      = toggle_s & level_r;

  // Shift each raw pad level through its synchroniser chain (stage 0 first).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], bus.btn_raw};
    end
  end

  // Debounce: clear when input agrees with the level, toggle at the terminal count, else count.
  always_comb begin
    cnt_nxt_s = cnt_r;
    toggle_s  = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (sync_s[i] == level_r[i]) begin
        cnt_nxt_s[i] = '0;
      end else if (cnt_r[i] == CNT_LAST) begin
        cnt_nxt_s[i] = '0;
        toggle_s[i]  = 1'b1;
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1'b1);
      end
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 1);

  logic [N_BTN-1:0][RPT_W-1:0] rpt_cnt_r;
  logic [N_BTN-1:0][RPT_W-1:0] rpt_cnt_nxt_s;
  logic [N_BTN-1:0]            rpt_act_r;
  logic [N_BTN-1:0]            rpt_act_nxt_s;

  // Repeat timer: armed by a press, cleared by a release; a release on the due edge wins.
  always_comb begin
    rpt_cnt_nxt_s = rpt_cnt_r;
    rpt_act_nxt_s = rpt_act_r;
    rpt_fire_s    = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (!REPEAT_MASK[i]) begin
        rpt_act_nxt_s[i] = 1'b0;
        rpt_cnt_nxt_s[i] = '0;
      end else if (rise_s[i]) begin
        rpt_act_nxt_s[i] = 1'b1;
        rpt_cnt_nxt_s[i] = RPT_FIRST;
      end else if (fall_s[i] || !level_r[i]) begin
        rpt_act_nxt_s[i] = 1'b0;
        rpt_cnt_nxt_s[i] = '0;
      end else if (rpt_act_r[i] && (rpt_cnt_r[i] == '0)) begin
        rpt_fire_s[i]    = 1'b1;
        rpt_cnt_nxt_s[i] = RPT_NEXT;
      end else if (rpt_act_r[i]) begin
        rpt_cnt_nxt_s[i] = rpt_cnt_r[i] - RPT_W'(1'b1);
      end else begin
        rpt_cnt_nxt_s[i] = rpt_cnt_r[i];
      end
    end
  end

  // Repeat timer state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rpt_cnt_r <= '0;
      rpt_act_r <= '0;
    end else begin
      rpt_cnt_r <= rpt_cnt_nxt_s;
      rpt_act_r <= rpt_act_nxt_s;
    end
  end
`else
  // Without auto-repeat, a press fires exactly once.
  assign rpt_fire_s = '0;

  logic unused_rpt_s;
  assign unused_rpt_s = ^{REPEAT_MASK, REPEAT_DELAY[0], REPEAT_PERIOD[0]};
`endif

  // Counters, debounced level, its inverse and the one-cycle strobes, all registered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r     <= '0;
      level_r   <= '0;
      btn_n_r   <= '1;
      press_r   <= '0;
      release_r <= '0;
    end else begin
      cnt_r     <= cnt_nxt_s;
      level_r   <= level_nxt_s;
      btn_n_r   <= ~level_nxt_s;
      press_r   <= rise_s | rpt_fire_s;
      release_r <= fall_s;
    end
  end

  assign bus.btn_level     = level_r;
  assign bus.btn_n         = btn_n_r;
  assign bus.press_pulse   = press_r;
  assign bus.release_pulse = release_r;

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed vectors, hand sequences and randomized stimulus
// against a window-based reference model of the button conditioner.
module tb_btn_conditioner;
  localparam int N    = 6;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int DLY  = 10;
  localparam int PER  = 5;
  localparam int HMAX = 2047;
  localparam logic [N-1:0] RMASK = 6'b001111;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  btn_conditioner_if #(.N_BTN(N)) bus ();

  btn_conditioner #(
    .N_BTN(N), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .CNT_W(2),
    .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER), .REPEAT_MASK(RMASK)
  ) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Reference model state: raw samples per edge since reset, toggle/press history.
  logic [N-1:0] raw_hist [0:HMAX];
  int           n_edge;
  logic [N-1:0] m_level, m_press, m_release;
  int           last_tog   [N];
  int           press_edge [N];
  bit           settled;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic sync_at(input int k, input int i);
    if (k > SYNC) return raw_hist[k-SYNC][i];
    else return 1'b0;
  endfunction

  task automatic model_reset();
    n_edge = 0; m_level = '0; m_press = '0; m_release = '0;
    for (int i = 0; i < N; i++) begin last_tog[i] = 0; press_edge[i] = 0; end
  endtask

  // Level changes once the synchronised input has disagreed with it for the
  // last DEB edges, all after the previous change.
  task automatic model_edge(input logic [N-1:0] raw);
    n_edge++;
    if (n_edge <= HMAX) raw_hist[n_edge] = raw;
    m_press = '0; m_release = '0;
    for (int i = 0; i < N; i++) begin
      settled = (n_edge - DEB + 1) > last_tog[i];
      for (int k = n_edge - DEB + 1; k <= n_edge; k++)
        if (settled && (sync_at(k, i) == m_level[i])) settled = 1'b0;
      if (settled) begin
        m_level[i] = ~m_level[i];
        last_tog[i] = n_edge;
        if (m_level[i]) begin m_press[i] = 1'b1; press_edge[i] = n_edge; end
        else m_release[i] = 1'b1;
      end
`ifdef BTN_AUTOREPEAT_EN
      else if (m_level[i] && RMASK[i] && (n_edge >= press_edge[i] + DLY) &&
               (((n_edge - press_edge[i] - DLY) % PER) == 0))
        m_press[i] = 1'b1;
`endif
    end
  endtask

  task automatic step(input logic [N-1:0] raw);
    bus.btn_raw = raw;
    @(posedge clock);
    model_edge(raw);
    #2;
    chk("model_level",   bus.btn_level,     m_level);
    chk("model_btn_n",   bus.btn_n,         ~m_level);
    chk("model_press",   bus.press_pulse,   m_press);
    chk("model_release", bus.release_pulse, m_release);
  endtask

  task automatic apply_reset(input logic [N-1:0] raw);
    bus.btn_raw = raw;
    reset_n = 1'b0;
    model_reset();
    @(posedge clock); #2;
    @(posedge clock); #2;
    chk("rst_level",   bus.btn_level,     6'h00);
    chk("rst_btn_n",   bus.btn_n,         6'h3F);
    chk("rst_press",   bus.press_pulse,   6'h00);
    chk("rst_release", bus.release_pulse, 6'h00);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0] raw;
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rel;
  } vec_t;

  vec_t         tbl [16];
  logic [N-1:0] r;
  logic         exp_p;

  initial begin
    // Reset with all buttons held, then release: one press on all channels at edge 6.
    apply_reset(6'h3F);
    for (int e = 1; e <= 7; e++) begin
      step(6'h3F);
      chk("hold_press", bus.press_pulse, (e == 6) ? 6'h3F : 6'h00);
      chk("hold_btn_n", bus.btn_n, (e >= 6) ? 6'h00 : 6'h3F);
    end

    // Clean press on 0, 3-cycle glitch on 3, bounce on 1, then 2/5 rise as 0 falls.
    tbl[0]  = '{6'h0B, 6'h00, 6'h00, 6'h00};
    tbl[1]  = '{6'h09, 6'h00, 6'h00, 6'h00};
    tbl[2]  = '{6'h0B, 6'h00, 6'h00, 6'h00};
    tbl[3]  = '{6'h03, 6'h00, 6'h00, 6'h00};
    tbl[4]  = '{6'h03, 6'h00, 6'h00, 6'h00};
    tbl[5]  = '{6'h03, 6'h01, 6'h01, 6'h00};
    tbl[6]  = '{6'h03, 6'h01, 6'h00, 6'h00};
    tbl[7]  = '{6'h03, 6'h03, 6'h02, 6'h00};
    tbl[8]  = '{6'h03, 6'h03, 6'h00, 6'h00};
    for (int j = 9; j < 14; j++) tbl[j] = '{6'h26, 6'h03, 6'h00, 6'h00};
    tbl[14] = '{6'h26, 6'h26, 6'h24, 6'h01};
    tbl[15] = '{6'h26, 6'h26, 6'h00, 6'h00};
    apply_reset(6'h00);
    step(6'h00);
    step(6'h00);
    for (int j = 0; j < 16; j++) begin
      step(tbl[j].raw);
      chk("tbl_level",   bus.btn_level,     tbl[j].lvl);
      chk("tbl_btn_n",   bus.btn_n,         ~tbl[j].lvl);
      chk("tbl_press",   bus.press_pulse,   tbl[j].prs);
      chk("tbl_release", bus.release_pulse, tbl[j].rel);
    end

    // Reset while channel 4 is mid-count: no pulse, full latency from scratch.
    apply_reset(6'h00);
    step(6'h00);
    for (int e = 1; e <= 4; e++) begin
      step(6'h10);
      chk("mid_no_press", bus.press_pulse, 6'h00);
    end
    apply_reset(6'h10);
    for (int e = 1; e <= 7; e++) begin
      step(6'h10);
      chk("mid_press", bus.press_pulse, (e == 6) ? 6'h10 : 6'h00);
      chk("mid_level", bus.btn_level, (e >= 6) ? 6'h10 : 6'h00);
    end

    // Long hold on channel 0 for edges 1..30: repeats only with auto-repeat built in.
    apply_reset(6'h00);
    for (int e = 1; e <= 40; e++) begin
      step((e <= 30) ? 6'h01 : 6'h00);
`ifdef BTN_AUTOREPEAT_EN
      exp_p = (e == 6) || (e == 16) || (e == 21) || (e == 26) || (e == 31);
`else
      exp_p = (e == 6);
`endif
      chk("rpt_press",   {5'b00000, bus.press_pulse[0]},   {5'b00000, exp_p});
      chk("rpt_release", {5'b00000, bus.release_pulse[0]}, (e == 36) ? 6'h01 : 6'h00);
    end

    // Randomized slow-toggling pads with periodic resets, checked against the model.
    r = '0;
    for (int c = 0; c < 1500; c++) begin
      if ((c % 400) == 0) apply_reset(r);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 15) == 0) r[i] = ~r[i];
      step(r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
